dct_idct_stream_scheduler: RTL and testbench
============================================

// Module: dct_idct_stream_scheduler
// PURPOSE
//  Sequences a frame of 8x8 pixel blocks through the dct -> idct chain. Gates the pixel stream into
//  dct on its reading strobe, drives dct start, counts 64-sample output windows from dct and idct,
//  and schedules idct rapx (approximate-precision enable) per idct block from a programmable window.
//  Replaces ad-hoc cycle-count rapx toggling; sits between the pixel source and the dct/idct pair.
// PARAMETERS
//  BitWidth       31      MSB index of pixel/data buses (bus width BitWidth+1)
//  BLK_SAMPLES    64      samples per block (8x8)
//  CNT_W          16      width of block counters/indices
//  DRAIN_TIMEOUT  16384   idle cycles in DRAIN with no idct_done before abort
// PORTS
//  clk          in   1           single clock, all logic rising-edge
//  reset        in   1           asynchronous, active-low
//  go           in   1           1-cycle pulse in IDLE: start frame (ignored elsewhere)
//  num_blocks   in   CNT_W       blocks in frame, sampled on go; 0 -> straight to DONE
//  apx_first    in   CNT_W       first idct block index with rapx=1, sampled on go
//  apx_last     in   CNT_W       last idct block index with rapx=1 (inclusive), sampled on go
//  pix_valid    in   1           source has pixel on pix_data
//  pix_data     in   BitWidth+1  pixel sample
//  pix_ready    out  1           pixel accepted this cycle when pix_valid&pix_ready
//  dct_start    out  1           to dct start
//  dct_reading  in   1           from dct reading
//  dct_din      out  BitWidth+1  to dct din, registered
//  dct_done     in   1           from dct done (high for a 64-sample output window)
//  idct_done    in   1           from idct done
//  rapx         out  1           to idct rapx
//  busy         out  1           state != IDLE
//  frame_done   out  1           1-cycle pulse on entering DONE
//  underrun     out  1           sticky: dct_reading high in FEED with pix_valid low; clear on go
//  timeout_err  out  1           sticky: DRAIN_TIMEOUT expired; clear on go
//  idct_blk_idx out  CNT_W       index of idct block currently/last output
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; all outputs 0; all counters 0; dct_din 0.
//  FSM: IDLE -go-> FEED (num_blocks!=0) or DONE (num_blocks==0);
//       FEED -> DRAIN when in_blk==num_blocks && dct_reading==0; DRAIN -> DONE when
//       idct blocks == num_blocks, or timeout; DONE -> IDLE next cycle (frame_done pulses in DONE).
//  FEED: dct_start=1 while in_blk<num_blocks, else 0. pix_ready = dct_reading & (in_blk<num_blocks).
//   On accept: dct_din<=pix_data (1-cycle latency), in_smp++; in_smp wraps 63->0 with in_blk++.
//   No accept when in_blk==num_blocks; excess dct_reading ignored. dct_din holds last value otherwise.
//  Output window counting (dct and idct independently): each cycle with done==1 counts a sample,
//   max 64 per window; counter reset when done==0; a window reaching 64 samples counts one block.
//   Done high >64 cycles: extra samples ignored, still one block. Window <64 then drop: not counted.
//  rapx: registered; at start of each idct window (idct_done 0->1) with block index k,
//   rapx<=(apx_first<=k<=apx_last); held through window and until next window. apx_first>apx_last
//   -> rapx always 0. idct_blk_idx<=k on the same edge. rapx 0 in IDLE; first window k=0.
//  Timeout: DRAIN cycle counter cleared on any idct_done=1; reaching DRAIN_TIMEOUT sets timeout_err
//   and forces DONE. Counter also runs in FEED? No: only DRAIN.
//  go while busy: ignored. go and reset same edge: reset wins. Inputs num_blocks/apx_* changed
//   mid-frame: no effect (sampled copies used).
//  Arithmetic: block counters saturate at 2^CNT_W-1; data bus passed unmodified (no truncation/sign ops).
// TESTING
//  1 block, pix_valid=1, dct_reading 64 cycles high -> 64 accepts, dct_din==pix_data delayed 1 cycle,
//    dct_start falls after 64th accept, one idct window of 64 -> frame_done pulse, busy=0.
//  num_blocks=4, apx_first=1, apx_last=2 -> rapx per idct window = 0,1,1,0; idct_blk_idx 0..3.
//  num_blocks=0, go -> frame_done next cycle, dct_start never asserted, pix_ready never high.
//  pix_valid=0 for 3 cycles while dct_reading=1 in FEED -> underrun=1, no accepts in those cycles,
//    underrun stays 1 until next go.
//  num_blocks=2, idct produces 1 window then idles -> timeout_err=1 after 16384 DRAIN cycles, DONE.
//  reset pulled low mid-FEED (in_smp=30) -> all outputs 0 immediately; after release, go restarts
//    cleanly with in_smp=0, in_blk=0; apx_first=5>apx_last=3 frame -> rapx stays 0.

Source files
------------

// File: rtl/dct_idct_stream_scheduler.sv
// Frame scheduler for the dct -> idct chain: gates pixels into dct, counts 64-sample
// output windows from both cores and programs idct rapx per block from a sampled window.
module dct_idct_stream_scheduler #(
  parameter int BitWidth      = 31,
  parameter int BLK_SAMPLES   = 64,
  parameter int CNT_W         = 16,
  parameter int DRAIN_TIMEOUT = 16384
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [CNT_W-1:0]    num_blocks,
  input  logic [CNT_W-1:0]    apx_first,
  input  logic [CNT_W-1:0]    apx_last,
  input  logic                pix_valid,
  input  logic [BitWidth:0]   pix_data,
  output logic                pix_ready,
  output logic                dct_start,
  input  logic                dct_reading,
  output logic [BitWidth:0]   dct_din,
  input  logic                dct_done,
  input  logic                idct_done,
  output logic                rapx,
  output logic                busy,
  output logic                frame_done,
  output logic                underrun,
  output logic                timeout_err,
  output logic [CNT_W-1:0]    idct_blk_idx
);

  localparam int SMP_W = $clog2(BLK_SAMPLES);
  localparam int WIN_W = $clog2(BLK_SAMPLES + 1);
  localparam int TO_W  = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(BLK_SAMPLES - 1);
  localparam logic [WIN_W-1:0] WIN_FULL = WIN_W'(BLK_SAMPLES);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(BLK_SAMPLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BLK_MAX  = '1;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   nblk_q, nblk_d, afirst_q, afirst_d, alast_q, alast_d;
  logic [SMP_W-1:0]   in_smp_q, in_smp_d;
  logic [CNT_W-1:0]   in_blk_q, in_blk_d;
  logic [BitWidth:0]  din_q, din_d;
  logic [WIN_W-1:0]   dct_win_q, dct_win_d, idct_win_q, idct_win_d;
  logic [CNT_W-1:0]   dct_blk_q, dct_blk_d, idct_blk_q, idct_blk_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               rapx_q, rapx_d, underrun_q, underrun_d, timeout_q, timeout_d;
  logic [TO_W-1:0]    drain_q, drain_d;
  logic               has_room;

  always_comb begin
    state_d    = state_q;
    nblk_d     = nblk_q;
    afirst_d   = afirst_q;
    alast_d    = alast_q;
    in_smp_d   = in_smp_q;
    in_blk_d   = in_blk_q;
    din_d      = din_q;
    dct_win_d  = dct_win_q;
    idct_win_d = idct_win_q;
    dct_blk_d  = dct_blk_q;
    idct_blk_d = idct_blk_q;
    idx_d      = idx_q;
    rapx_d     = rapx_q;
    underrun_d = underrun_q;
    timeout_d  = timeout_q;
    drain_d    = drain_q;
    pix_ready  = 1'b0;
    dct_start  = 1'b0;
    has_room   = in_blk_q < nblk_q;

    // Window counters: samples beyond a full window are ignored, short windows never count.
    if (dct_done) begin
      if (dct_win_q != WIN_FULL) begin
        dct_win_d = dct_win_q + 1'b1;
        if (dct_win_q == WIN_LAST && dct_blk_q != BLK_MAX) dct_blk_d = dct_blk_q + 1'b1;
      end
    end else begin
      dct_win_d = '0;
    end

    if (idct_done) begin
      if (idct_win_q != WIN_FULL) begin
        idct_win_d = idct_win_q + 1'b1;
        if (idct_win_q == WIN_LAST && idct_blk_q != BLK_MAX) idct_blk_d = idct_blk_q + 1'b1;
      end
      if (idct_win_q == '0 && state_q != IDLE) begin
        idx_d  = idct_blk_q;
        rapx_d = (afirst_q <= idct_blk_q) && (idct_blk_q <= alast_q);
      end
    end else begin
      idct_win_d = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (go) begin
          nblk_d     = num_blocks;
          afirst_d   = apx_first;
          alast_d    = apx_last;
          in_smp_d   = '0;
          in_blk_d   = '0;
          dct_blk_d  = '0;
          idct_blk_d = '0;
          idx_d      = '0;
          underrun_d = 1'b0;
          timeout_d  = 1'b0;
          drain_d    = '0;
          state_d    = (num_blocks == '0) ? DONE : FEED;
        end
      end
      FEED: begin
        dct_start = has_room;
        pix_ready = dct_reading & has_room;
        if (pix_ready && pix_valid) begin
          din_d = pix_data;
          if (in_smp_q == SMP_LAST) begin
            in_smp_d = '0;
            if (in_blk_q != BLK_MAX) in_blk_d = in_blk_q + 1'b1;
          end else begin
            in_smp_d = in_smp_q + 1'b1;
          end
        end
        if (dct_reading && !pix_valid) underrun_d = 1'b1;
        if (!has_room && !dct_reading) state_d = DRAIN;
      end
      DRAIN: begin
        drain_d = idct_done ? '0 : drain_q + 1'b1;
        // idct can only legitimately finish after dct has delivered every block
        if (idct_blk_q == nblk_q && dct_blk_q >= nblk_q) begin
          state_d = DONE;
        end else if (!idct_done && drain_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) rapx_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      nblk_q     <= '0;
      afirst_q   <= '0;
      alast_q    <= '0;
      in_smp_q   <= '0;
      in_blk_q   <= '0;
      din_q      <= '0;
      dct_win_q  <= '0;
      idct_win_q <= '0;
      dct_blk_q  <= '0;
      idct_blk_q <= '0;
      idx_q      <= '0;
      rapx_q     <= 1'b0;
      underrun_q <= 1'b0;
      timeout_q  <= 1'b0;
      drain_q    <= '0;
    end else begin
      state_q    <= state_d;
      nblk_q     <= nblk_d;
      afirst_q   <= afirst_d;
      alast_q    <= alast_d;
      in_smp_q   <= in_smp_d;
      in_blk_q   <= in_blk_d;
      din_q      <= din_d;
      dct_win_q  <= dct_win_d;
      idct_win_q <= idct_win_d;
      dct_blk_q  <= dct_blk_d;
      idct_blk_q <= idct_blk_d;
      idx_q      <= idx_d;
      rapx_q     <= rapx_d;
      underrun_q <= underrun_d;
      timeout_q  <= timeout_d;
      drain_q    <= drain_d;
    end
  end

  assign dct_din      = din_q;
  assign rapx         = rapx_q;
  assign busy         = (state_q != IDLE);
  assign frame_done   = (state_q == DONE);
  assign underrun     = underrun_q;
  assign timeout_err  = timeout_q;
  assign idct_blk_idx = idx_q;

endmodule

// File: tb/tb_dct_idct_stream_scheduler.sv
// Directed-random bench for dct_idct_stream_scheduler with a frame-level reference model.
module tb_dct_idct_stream_scheduler;

  localparam int TO = 16384;

  logic        clk, reset, go;
  logic [15:0] num_blocks, apx_first, apx_last;
  logic        pix_valid, pix_ready, dct_start, dct_reading, dct_done, idct_done;
  logic [31:0] pix_data, dct_din;
  logic        rapx, busy, frame_done, underrun, timeout_err;
  logic [15:0] idct_blk_idx;

  dct_idct_stream_scheduler #(
    .BitWidth(31), .BLK_SAMPLES(64), .CNT_W(16), .DRAIN_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .num_blocks(num_blocks),
    .apx_first(apx_first), .apx_last(apx_last), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_ready(pix_ready), .dct_start(dct_start),
    .dct_reading(dct_reading), .dct_din(dct_din), .dct_done(dct_done),
    .idct_done(idct_done), .rapx(rapx), .busy(busy), .frame_done(frame_done),
    .underrun(underrun), .timeout_err(timeout_err), .idct_blk_idx(idct_blk_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // Frame-level model state
  int          m_nb, m_af, m_al, m_acc, m_kdone;
  logic [31:0] m_din;
  logic        m_underrun, m_timeout, m_rapx;
  int          m_idx;
  int          n_wait;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".dct_din"}, dct_din, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".dct_start"}, dct_start, 0);
    chk({tag, ".pix_ready"}, pix_ready, 0);
    chk({tag, ".rapx"}, rapx, 0);
    chk({tag, ".frame_done"}, frame_done, 0);
    chk({tag, ".underrun"}, underrun, 0);
    chk({tag, ".timeout_err"}, timeout_err, 0);
    chk({tag, ".idct_blk_idx"}, idct_blk_idx, 0);
  endtask

  task automatic start_frame(input int nb, input int af, input int al);
    go = 1'b1; num_blocks = 16'(nb); apx_first = 16'(af); apx_last = 16'(al);
    tick();
    go = 1'b0;
    num_blocks = 16'($urandom); apx_first = 16'($urandom); apx_last = 16'($urandom);
    m_nb = nb; m_af = af; m_al = al; m_acc = 0; m_kdone = 0;
    m_underrun = 1'b0; m_timeout = 1'b0; m_rapx = 1'b0; m_idx = 0;
    chk("start.busy", busy, 1);
    chk("start.underrun_cleared", underrun, 0);
    chk("start.timeout_cleared", timeout_err, 0);
  endtask

  // Feed until target accepts; gap_at >= 0 forces 3 starved cycles with dct_reading=1.
  task automatic feed(input int target, input int gap_at, input bit finish);
    int cyc = 0;
    bit exp_ready;
    while (m_acc < target && cyc < target * 4 + 64) begin
      dct_reading = ($urandom % 8) != 0;
      pix_valid   = 1'b1;
      if (gap_at >= 0 && cyc >= gap_at && cyc < gap_at + 3) begin
        dct_reading = 1'b1;
        pix_valid   = 1'b0;
      end
      pix_data = $urandom;
      go = (($urandom % 16) == 0);
      num_blocks = 16'($urandom % 3);
      #1;
      exp_ready = dct_reading && (m_acc < m_nb * 64);
      chk("feed.pix_ready", pix_ready, exp_ready);
      chk("feed.dct_start", dct_start, (m_acc < m_nb * 64));
      tick();
      go = 1'b0;
      if (exp_ready && pix_valid) begin
        m_acc++;
        m_din = pix_data;
      end
      if (dct_reading && !pix_valid) m_underrun = 1'b1;
      chk("feed.dct_din", dct_din, m_din);
      chk("feed.underrun", underrun, m_underrun);
      chk("feed.busy", busy, 1);
      cyc++;
    end
    chk("feed.accept_count", m_acc, target);
    if (finish) begin
      for (int i = 0; i < 2; i++) begin
        dct_reading = 1'b1; pix_valid = 1'b1; pix_data = $urandom;
        #1;
        chk("excess.pix_ready", pix_ready, 0);
        chk("excess.dct_start", dct_start, 0);
        tick();
        chk("excess.dct_din_held", dct_din, m_din);
      end
      dct_reading = 1'b0; pix_valid = 1'b0;
      tick();
      chk("drain.busy", busy, 1);
    end
  endtask

  // n_full full windows on both dct and idct; a short window is inserted before index short_at.
  task automatic windows(input int n_full, input int short_at, input bit final_exact);
    int len;
    for (int w = 0; w < n_full; w++) begin
      if (w == short_at) begin
        dct_done = 1'b1; idct_done = 1'b1;
        for (int c = 0; c < 10; c++) begin
          tick();
          if (c == 0) begin
            m_rapx = (m_af <= m_kdone) && (m_kdone <= m_al);
            m_idx  = m_kdone;
          end
        end
        chk("short.rapx", rapx, m_rapx);
        dct_done = 1'b0; idct_done = 1'b0;
        tick();
        chk("short.busy", busy, 1);
      end
      len = (final_exact && w == n_full - 1) ? 64 : 64 + int'($urandom % 4);
      dct_done = 1'b1; idct_done = 1'b1;
      for (int c = 0; c < len; c++) begin
        tick();
        if (c == 0) begin
          m_rapx = (m_af <= m_kdone) && (m_kdone <= m_al);
          m_idx  = m_kdone;
          chk("win.rapx", rapx, m_rapx);
          chk("win.idct_blk_idx", idct_blk_idx, m_idx);
        end
        if (c == 63) m_kdone++;
      end
      chk("win.rapx_end", rapx, m_rapx);
      if (w != n_full - 1) begin
        dct_done = 1'b0; idct_done = 1'b0;
        for (int g = 0; g < 1 + int'($urandom % 3); g++) begin
          tick();
          chk("gap.rapx_held", rapx, m_rapx);
          chk("gap.frame_done", frame_done, 0);
        end
      end
    end
  endtask

  task automatic wait_done(input int max_cyc);
    dct_done = 1'b0; idct_done = 1'b0;
    n_wait = 0;
    while (!frame_done && n_wait < max_cyc) begin
      tick();
      n_wait++;
    end
    chk("frame_done_seen", frame_done, 1);
    chk("done.timeout_err", timeout_err, m_timeout);
    chk("done.idct_blk_idx", idct_blk_idx, m_idx);
    tick();
    chk("done.frame_done_pulse", frame_done, 0);
    chk("done.busy", busy, 0);
    chk("done.rapx_idle", rapx, 0);
  endtask

  initial begin
    reset = 1'b0; go = 1'b0; num_blocks = '0; apx_first = '0; apx_last = '0;
    pix_valid = 1'b0; pix_data = '0; dct_reading = 1'b0; dct_done = 1'b0; idct_done = 1'b0;
    m_din = '0;
    #3;
    chk_all_zero("reset");
    tick(); tick();
    reset = 1'b1;
    tick();
    chk_all_zero("post_reset");

    // One block, rapx window covers block 0
    start_frame(1, 0, 0);
    feed(64, -1, 1'b1);
    windows(1, -1, 1'b1);
    wait_done(8);
    chk("f1.done_latency", n_wait, 1);
    chk("f1.underrun", underrun, 0);

    // Four blocks, rapx 0,1,1,0 with a short window that must not count; starvation gap
    start_frame(4, 1, 2);
    feed(256, 100, 1'b1);
    chk("f4.underrun_set", underrun, 1);
    windows(4, 2, 1'b1);
    wait_done(8);
    chk("f4.underrun_sticky", underrun, 1);
    chk("f4.last_idx", idct_blk_idx, 3);

    // Zero-block frame
    dct_reading = 1'b1; pix_valid = 1'b1;
    start_frame(0, 0, 0);
    chk("f0.frame_done", frame_done, 1);
    chk("f0.dct_start", dct_start, 0);
    chk("f0.pix_ready", pix_ready, 0);
    tick();
    chk("f0.busy", busy, 0);
    chk("f0.pix_ready_idle", pix_ready, 0);
    dct_reading = 1'b0; pix_valid = 1'b0;

    // Two blocks, idct delivers only one window -> drain timeout
    start_frame(2, 0, 15);
    feed(128, -1, 1'b1);
    windows(1, -1, 1'b0);
    m_timeout = 1'b1;
    wait_done(TO + 16);
    chk("to.idle_cycles", n_wait, TO);
    chk("to.timeout_sticky", timeout_err, 1);

    // Async reset mid-FEED, then a clean restart with an empty rapx window
    start_frame(2, 0, 3);
    feed(30, -1, 1'b0);
    reset = 1'b0;
    dct_reading = 1'b0; pix_valid = 1'b0;
    #1;
    chk_all_zero("midreset");
    tick();
    reset = 1'b1;
    tick();
    m_din = '0;
    start_frame(1, 5, 3);
    feed(64, -1, 1'b1);
    windows(1, 0, 1'b1);
    wait_done(8);
    chk("inv.rapx_never", m_rapx, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
